// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state, bit-order and counter-width definitions
// Reused by the matching deserializer so both ends agree on encodings.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  // Bits needed to count 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel load port and serial output stream bundle
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_serializer_shreg.sv
// rtl/piso_serializer_shreg.sv - loadable shift register with selectable bit order
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with one-word holding buffer
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);
  import piso_serializer_pkg::*;

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] hold;
  logic             hold_full, hold_full_d, hold_we;
  logic             load, shift;
  logic [WIDTH-1:0] load_word;
  logic             accept, at_last, shreg_bit;

  assign accept  = bus.din_valid & ~hold_full;
  assign at_last = (state == ST_SHIFT) && (cnt == CNT_LAST);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hold_full_d = hold_full;
    hold_we     = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    load_word   = bus.din;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!at_last) begin
          shift = 1'b1;
          cnt_d = cnt + CW'(1);
          if (accept) begin
            hold_we     = 1'b1;
            hold_full_d = 1'b1;
          end
        end else if (hold_full) begin
          // Held word takes priority; din_ready is low so no accept can race it.
          load        = 1'b1;
          load_word   = hold;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          load  = 1'b1;
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hold_full <= hold_full_d;
      if (hold_we) hold <= bus.din;
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (load_word),
    .sout  (shreg_bit)
  );

  assign bus.din_ready  = ~hold_full;
  assign bus.sout_valid = (state == ST_SHIFT);
  assign bus.sout       = (state == ST_SHIFT) & shreg_bit;
  assign bus.sout_last  = at_last;
  assign bus.busy       = (state == ST_SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer, LSB-first and MSB-first
module tb_piso_serializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) b0 ();
  piso_serializer_if #(.WIDTH(W)) b1 ();

  assign b1.din       = b0.din;
  assign b1.din_valid = b0.din_valid;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(piso_serializer_pkg::LSB_FIRST)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(piso_serializer_pkg::MSB_FIRST)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of {bit,last} still to appear on sout; head is the bit shown now.
  // The hold slot is occupied exactly when more than one frame's worth is queued.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  bit acc0, acc1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      acc0 = b0.din_valid && (q0.size() <= W);
      acc1 = b0.din_valid && (q1.size() <= W);
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc0) for (int i = 0; i < W; i++) q0.push_back({b0.din[i], i == W - 1});
      if (acc1) for (int i = 0; i < W; i++) q1.push_back({b0.din[W-1-i], i == W - 1});
    end
  end

  logic [31:0] cap0_bits = 0, cap0_last = 0, cap1_bits = 0, cap1_last = 0;
  int cap0_n = 0, cap1_n = 0;

  task automatic cmp(input string tag, input logic v, input logic s, input logic l,
                     input logic bz, input logic rdy, input int n, input logic [1:0] head);
    chk({tag, ".sout_valid"}, v, n > 0);
    chk({tag, ".sout"}, s, (n > 0) ? head[1] : 1'b0);
    chk({tag, ".sout_last"}, l, (n > 0) ? head[0] : 1'b0);
    chk({tag, ".busy"}, bz, n > 0);
    chk({tag, ".din_ready"}, rdy, n <= W);
  endtask

  always @(negedge clk) begin
    cmp("d0", b0.sout_valid, b0.sout, b0.sout_last, b0.busy, b0.din_ready,
        q0.size(), (q0.size() > 0) ? q0[0] : 2'b00);
    cmp("d1", b1.sout_valid, b1.sout, b1.sout_last, b1.busy, b1.din_ready,
        q1.size(), (q1.size() > 0) ? q1[0] : 2'b00);
    if (b0.sout_valid) begin
      cap0_bits = {cap0_bits[30:0], b0.sout};
      cap0_last = {cap0_last[30:0], b0.sout_last};
      cap0_n++;
    end
    if (b1.sout_valid) begin
      cap1_bits = {cap1_bits[30:0], b1.sout};
      cap1_last = {cap1_last[30:0], b1.sout_last};
      cap1_n++;
    end
  end

  task automatic clr();
    cap0_bits = 0; cap0_last = 0; cap0_n = 0;
    cap1_bits = 0; cap1_last = 0; cap1_n = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    b0.din       = 4'b1010;
    b0.din_valid = 1'b1;
    tick(3);
    chk("rst_sout_valid", b0.sout_valid, 0);
    chk("rst_sout", b0.sout, 0);
    chk("rst_sout_last", b0.sout_last, 0);
    chk("rst_busy", b0.busy, 0);

    // Single word 1010
    rst = 1'b1;
    #1;
    chk("rel_ready", b0.din_ready, 1);
    tick(1);
    b0.din_valid = 1'b0;
    chk("first_valid", b0.sout_valid, 1);
    chk("first_sout", b0.sout, 0);
    tick(6);
    chk("single_bits_lsb", cap0_bits, 4'b0101);
    chk("single_last_lsb", cap0_last, 4'b0001);
    chk("single_n_lsb", cap0_n, 4);
    chk("single_bits_msb", cap1_bits, 4'b1010);
    chk("single_idle_busy", b0.busy, 0);

    // Back-to-back 1010 then 1000
    clr();
    b0.din = 4'b1010; b0.din_valid = 1'b1;
    tick(1);
    b0.din = 4'b1000;
    tick(1);
    chk("b2b_ready_low", b0.din_ready, 0);
    b0.din_valid = 1'b0;
    tick(10);
    chk("b2b_bits_lsb", cap0_bits, 8'b01010001);
    chk("b2b_last_lsb", cap0_last, 8'b00010001);
    chk("b2b_n_lsb", cap0_n, 8);
    chk("b2b_bits_msb", cap1_bits, 8'b10101000);
    chk("b2b_last_msb", cap1_last, 8'b00010001);

    // Bit order on 0110
    clr();
    b0.din = 4'b0110; b0.din_valid = 1'b1;
    tick(1);
    b0.din_valid = 1'b0;
    tick(6);
    chk("order_bits_msb", cap1_bits, 4'b0110);
    chk("order_bits_lsb", cap0_bits, 4'b0110);

    // din changes while hold is full must not be accepted
    clr();
    b0.din = 4'b1010; b0.din_valid = 1'b1;
    tick(1);
    b0.din = 4'b0011;
    tick(1);
    b0.din = 4'b1111;
    tick(3);
    b0.din_valid = 1'b0;
    tick(8);
    chk("holdchg_bits_lsb", cap0_bits, 8'b01011100);
    chk("holdchg_n_lsb", cap0_n, 8);
    chk("holdchg_bits_msb", cap1_bits, 8'b10100011);

    // Reset mid-frame discards the held word
    clr();
    b0.din = 4'b1010; b0.din_valid = 1'b1;
    tick(1);
    b0.din = 4'b0100;
    tick(1);
    b0.din_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", b0.sout_valid, 0);
    chk("mid_rst_sout", b0.sout, 0);
    chk("mid_rst_busy", b0.busy, 0);
    chk("mid_rst_ready", b0.din_ready, 1);
    tick(2);
    rst = 1'b1;
    clr();
    b0.din = 4'b0110; b0.din_valid = 1'b1;
    tick(1);
    b0.din_valid = 1'b0;
    tick(8);
    chk("post_rst_bits_lsb", cap0_bits, 4'b0110);
    chk("post_rst_n_lsb", cap0_n, 4);
    chk("post_rst_bits_msb", cap1_bits, 4'b0110);
    chk("post_rst_n_msb", cap1_n, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer with a valid/ready load port and a serial output stream marked by valid and last flags. It is the transmit-side counterpart to the team's parallel and serial-in capture registers: a word captured in parallel leaves here one bit per clock. A one-word holding buffer allows back-to-back words to stream with no idle cycle between frames.

Parameters:
WIDTH, 4, bits per word; legal range is 2 or more.
MSB_FIRST, 0, bit order: 0 shifts out bit 0 first, 1 shifts out bit WIDTH-1 first.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
din  input  WIDTH  parallel word to send.
din_valid  input  1  din holds a word to be sent.
din_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a bit of a frame.
sout_last  output  1  current bit is the final bit of the frame.
busy  output  1  a frame is shifting or a word is held.

Behaviour:
- Reset (rst=0, asynchronous):
  - shift register, hold register, hold_full, bit counter cleared; state = IDLE.
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - din_valid ignored while rst=0.
- States: IDLE and SHIFT. Counter width is $clog2(WIDTH) and counts 0..WIDTH-1.
- din_ready = ~hold_full, combinational.
- A word is accepted on a rising edge with din_valid & din_ready.
- Direct load: on the accept edge, if (IDLE, or SHIFT with count==WIDTH-1) and hold is empty, din loads the shifter, count=0, state=SHIFT. No hold write occurs.
- Hold write: any other accept writes din to the hold register and sets hold_full=1.
- In SHIFT, each edge with count<WIDTH-1 shifts the register one position toward the output end and increments count.
- Edge with count==WIDTH-1:
  - if hold_full: load shifter from hold, clear hold_full, count=0, stay in SHIFT;
  - else if direct load: as above;
  - else go to IDLE.
- Outputs:
  - sout = shifter bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1).
  - sout_valid = (state==SHIFT).
  - sout_last = SHIFT & count==WIDTH-1.
  - busy = SHIFT | hold_full.
  - All outputs are registered-state decodes with no combinational path from din.
  - In IDLE, sout is driven 0.
- Latency: first bit appears on sout in the cycle after the accept edge. A frame occupies exactly WIDTH cycles. Consecutive frames are gapless when the next word is accepted no later than the last-bit edge.
- Simultaneous events: at a last-bit edge with hold_full=1, din_ready is already 0, so no accept is possible. The hold register drains into the shifter, and din_ready rises the following cycle.
- din is sampled only at the accept edge; later changes do not affect the word in flight.
- Reset mid-frame: the frame is aborted with no completion and outputs go to 0 immediately. The held word is discarded.

Decomposition:
- Shared package: state encodings ST_IDLE/ST_SHIFT, bit-order constants LSB_FIRST/MSB_FIRST, and the counter-width function. The matching deserializer reuses these.
- Optional sub-module piso_shreg: WIDTH-bit loadable shift register with load, shift and bit-order parameter. All FSM, hold and handshake logic stays in the top module.

Test Plan:
- Assert rst=0 with din_valid=1 and din=4'b1010 -> sout/sout_valid/sout_last/busy all 0. Release reset -> din_ready=1, and the first accept happens on the next edge.
- WIDTH=4, MSB_FIRST=0, single word 4'b1010 -> sout 0,1,0,1 on 4 consecutive cycles, sout_valid=1 throughout, sout_last only on the 4th bit, then IDLE with busy=0.
- Back-to-back: hold din_valid=1 for 4'b1010 then 4'b1000 -> 8 contiguous valid cycles carrying 0,1,0,1,0,0,0,1. sout_last pulses on bits 4 and 8. din_ready=0 while hold_full.
- MSB_FIRST=1, din=4'b0110 -> sout 0,1,1,0.
- Change din while hold_full=1 with din_valid=1 -> no accept. The frame carries the originally accepted value.
- Pull rst=0 after 2 bits of 4'b1010 with 4'b0100 held -> outputs 0 asynchronously and the hold is cleared. After release, load 4'b0110 -> clean frame 0,1,1,0 and 4'b0100 is never emitted.
